// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, default widths and payload sizing for pipe_stage_skid
package pipe_pkg;

    // Occupancy-encoded states: the encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_CNT_W  = 16;

    // Packed payload layout, MSB to LSB: wb, m, alu, wdata, wreg
    function automatic int payload_w(input int wb_w, input int m_w,
                                     input int data_w, input int reg_w);
        return wb_w + m_w + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/stage_payload_reg.sv
// rtl/stage_payload_reg.sv - load-enabled payload register with asynchronous active-low clear
module stage_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the payload only when the stage decides to load this slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with optional skid slot, flush and stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [M_W-1:0]    in_m,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [M_W-1:0]    out_m,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_wreg,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW        = payload_w(WB_W, M_W, DATA_W, REG_W);
    localparam int OFF_WREG  = 0;
    localparam int OFF_WDATA = OFF_WREG + REG_W;
    localparam int OFF_ALU   = OFF_WDATA + DATA_W;
    localparam int OFF_M     = OFF_ALU + DATA_W;
    localparam int OFF_WB    = OFF_M + M_W;

    state_t          state;
    state_t          state_next;
    logic            main_valid;
    logic            in_fire;
    logic            out_fire;
    logic            main_load;
    logic            skid_load;
    logic            main_from_skid;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   main_d;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;

    assign in_payload = {in_wb, in_m, in_alu, in_wdata, in_wreg};
    assign main_valid = (state != ST_EMPTY);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_valid & out_ready;

    // Advance the occupancy state on each clock; reset drops every held entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Decide the next state and which slot captures what; flush overrides all
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire && SKID) begin
                    skid_load  = 1'b1;
                    state_next = ST_FULL;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_next     = ST_EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    stage_payload_reg #(.W(PW)) u_main_reg (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            stage_payload_reg #(.W(PW)) u_skid_reg (
                .clk  (clk),
                .rst  (rst),
                .load (skid_load),
                .d    (in_payload),
                .q    (skid_q)
            );

            // Registered ready: low exactly while both slots will be occupied
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_next != ST_FULL);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = !main_valid | out_ready;
        end
    endgenerate

    // Count cycles where upstream is blocked, saturating instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = main_valid;
    assign occupancy = state;
    // Control fields are masked on bubbles so nothing downstream acts on stale payload
    assign out_wb    = main_valid ? main_q[OFF_WB +: WB_W] : '0;
    assign out_m     = main_valid ? main_q[OFF_M +: M_W]   : '0;
    assign out_alu   = main_q[OFF_ALU +: DATA_W];
    assign out_wdata = main_q[OFF_WDATA +: DATA_W];
    assign out_wreg  = main_q[OFF_WREG +: REG_W];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb, m;
    logic [31:0] alu, wdata;
    logic [4:0]  wreg;

    logic v1, r1, fl1, ir1, ov1;
    logic [1:0]  owb1, om1, occ1;
    logic [31:0] oalu1, owd1;
    logic [4:0]  owr1;
    logic [15:0] sc1;

    logic v0, r0, fl0, ir0, ov0;
    logic [1:0]  owb0, om0, occ0;
    logic [31:0] oalu0, owd0;
    logic [4:0]  owr0;
    logic [15:0] sc0;

    logic v4, r4, fl4, ir4, ov4;
    logic [1:0]  owb4, om4, occ4;
    logic [31:0] oalu4, owd4;
    logic [4:0]  owr4;
    logic [3:0]  sc4;

    int n_assert = 0;
    int n_fail   = 0;
    int got      = 0;
    bit mv       = 1'b0;
    int nxt      = 1;

    always #5 clk = ~clk;

    pipe_stage_skid #(.SKID(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(v1), .in_ready(ir1),
        .in_wb(wb), .in_m(m), .in_alu(alu), .in_wdata(wdata), .in_wreg(wreg),
        .out_valid(ov1), .out_ready(r1), .out_wb(owb1), .out_m(om1),
        .out_alu(oalu1), .out_wdata(owd1), .out_wreg(owr1),
        .occupancy(occ1), .stall_cnt(sc1)
    );

    pipe_stage_skid #(.SKID(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(v0), .in_ready(ir0),
        .in_wb(wb), .in_m(m), .in_alu(alu), .in_wdata(wdata), .in_wreg(wreg),
        .out_valid(ov0), .out_ready(r0), .out_wb(owb0), .out_m(om0),
        .out_alu(oalu0), .out_wdata(owd0), .out_wreg(owr0),
        .occupancy(occ0), .stall_cnt(sc0)
    );

    pipe_stage_skid #(.SKID(1'b1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(fl4), .in_valid(v4), .in_ready(ir4),
        .in_wb(wb), .in_m(m), .in_alu(alu), .in_wdata(wdata), .in_wreg(wreg),
        .out_valid(ov4), .out_ready(r4), .out_wb(owb4), .out_m(om4),
        .out_alu(oalu4), .out_wdata(owd4), .out_wreg(owr4),
        .occupancy(occ4), .stall_cnt(sc4)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        v1 = 1'b1; v0 = 1'b1; v4 = 1'b1;
        r1 = 1'b0; r0 = 1'b0; r4 = 1'b0;
        fl1 = 1'b0; fl0 = 1'b0; fl4 = 1'b0;
        wb = 2'b11; m = 2'b11; alu = 32'hAA; wdata = 32'h0; wreg = 5'd3;

        // reset held with in_valid asserted
        repeat (3) tick();
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_out_wb", owb1, 2'b00);
        chk("rst_occupancy", occ1, 2'd0);
        chk("rst_stall_cnt", sc1, 16'd0);
        chk("rst_s0_out_valid", ov0, 1'b0);
        rst = 1'b1; v1 = 1'b0; v0 = 1'b0; v4 = 1'b0;
        #1;
        chk("rel_in_ready", ir1, 1'b1);
        chk("rel_s0_in_ready", ir0, 1'b1);

        // single transfer, one cycle latency
        @(negedge clk);
        wb = 2'b11; m = 2'b00; alu = 32'h0000_0010; wreg = 5'd8; v1 = 1'b1; r1 = 1'b1;
        tick();
        chk("lat_out_valid", ov1, 1'b1);
        chk("lat_out_alu", oalu1, 32'h10);
        chk("lat_out_wreg", owr1, 5'd8);
        chk("lat_out_wb", owb1, 2'b11);
        v1 = 1'b0;
        tick();
        chk("drain_out_valid", ov1, 1'b0);
        chk("bubble_out_wb", owb1, 2'b00);
        chk("drain_occupancy", occ1, 2'd0);

        // skid fill: A=1, B=2 accepted, C=3 waits
        r1 = 1'b0; v1 = 1'b1; alu = 32'd1;
        tick();
        alu = 32'd2;
        tick();
        chk("full_in_ready", ir1, 1'b0);
        chk("full_occupancy", occ1, 2'd2);
        chk("full_out_alu", oalu1, 32'd1);
        alu = 32'd3;
        tick();
        tick();
        chk("stall_cnt_2", sc1, 16'd2);
        chk("stable_out_alu", oalu1, 32'd1);
        r1 = 1'b1;
        tick();
        chk("order_2", oalu1, 32'd2);
        chk("stall_cnt_3", sc1, 16'd3);
        chk("reopen_in_ready", ir1, 1'b1);
        tick();
        chk("order_3", oalu1, 32'd3);
        chk("order_3_valid", ov1, 1'b1);
        v1 = 1'b0;
        tick();
        chk("order_empty", ov1, 1'b0);

        // flush from FULL with entry 9 offered
        r1 = 1'b0; v1 = 1'b1; m = 2'b11; alu = 32'd4;
        tick();
        alu = 32'd5;
        tick();
        chk("pre_flush_occ", occ1, 2'd2);
        alu = 32'd9; fl1 = 1'b1;
        tick();
        chk("flush_out_valid", ov1, 1'b0);
        chk("flush_out_m", om1, 2'b00);
        chk("flush_occupancy", occ1, 2'd0);
        chk("flush_stall_cnt", sc1, 16'd4);
        chk("flush_in_ready", ir1, 1'b1);
        fl1 = 1'b0; v1 = 1'b0;
        tick();
        chk("flush_no_9", ov1, 1'b0);

        // flush from ONE discards an accepted entry
        v1 = 1'b1; alu = 32'd6;
        tick();
        alu = 32'd9; fl1 = 1'b1;
        tick();
        chk("flush1_occupancy", occ1, 2'd0);
        fl1 = 1'b0; v1 = 1'b0;
        tick();
        chk("flush1_no_9", ov1, 1'b0);
        chk("flush1_stall_cnt", sc1, 16'd4);

        // SKID=0 streaming 1..8 with out_ready toggling
        for (int c = 0; c < 40 && got < 8; c++) begin
            r0 = (c % 2 == 0);
            v0 = (nxt <= 8);
            alu = nxt;
            #1;
            chk("s0_in_ready", ir0, !mv | r0);
            chk("s0_out_valid", ov0, mv);
            if (ov0 && r0) begin
                got++;
                chk("s0_order", oalu0, got);
            end
            if (v0 && (!mv || r0)) begin
                mv = 1'b1;
                nxt++;
            end else if (mv && r0) begin
                mv = 1'b0;
            end
            tick();
        end
        chk("s0_delivered", got, 8);
        v0 = 1'b0; r0 = 1'b1;
        tick();
        chk("s0_empty", ov0, 1'b0);

        // CNT_W=4 saturation
        v4 = 1'b1; r4 = 1'b0;
        repeat (10) tick();
        chk("sat_cnt_8", sc4, 4'd8);
        chk("sat_occupancy", occ4, 2'd2);
        repeat (12) tick();
        chk("sat_cnt_15", sc4, 4'd15);
        repeat (5) tick();
        chk("sat_hold_15", sc4, 4'd15);
        rst = 1'b0;
        #1;
        chk("sat_rst_clear", sc4, 4'd0);
        chk("rst_sc1_clear", sc1, 16'd0);
        rst = 1'b1;
        v4 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
